// File: rtl/mil1553_pkg.sv
// Shared definitions for the MIL-STD-1553 receive/transmit packet path:
// writer FSM states, trailer tag and default packet timing constants.
package mil1553_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_WAIT,
        ST_GAP,
        ST_TRAILER,
        ST_COMMIT,
        ST_ROLLBACK,
        ST_DISCARD
    } state_t;

    localparam logic [3:0]  TRAILER_TAG        = 4'hA;
    localparam int unsigned DEFAULT_GAP_CYCLES = 40;
    localparam int unsigned DEFAULT_MAX_WORDS  = 33;

endpackage

// File: rtl/gap_timer.sv
// Idle-gap counter: counts enabled cycles, clears on request, and flags
// expiry on the LIMIT-th consecutive enabled cycle (a clear always wins).
module gap_timer #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned LIMIT = 40
) (
    input  logic clk,
    input  logic nRst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ring_packet_writer.sv
// Writes each received 1553 packet into the ring buffer as one open/commit
// transaction, rolling back on error, overrun or oversize.
// Optional trailer word enabled by defining RING_PACKET_TRAILER_EN.
module ring_packet_writer
    import mil1553_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int unsigned MAX_WORDS  = DEFAULT_MAX_WORDS,
    parameter int unsigned CNT_W      = 16
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_error,
    output logic        push_request,
    output logic [15:0] push_data,
    input  logic        push_done,
    output logic        rb_open,
    output logic        rb_commit,
    output logic        rb_rollback,
    output logic        pkt_ok,
    output logic        pkt_drop
);

    state_t           state_q, state_d;
    logic [15:0]      hold_q;
    logic             full_q, abort_q, trailer_q;
    logic [CNT_W-1:0] count_q;

    logic        push_request_q, push_request_d;
    logic [15:0] push_data_q, push_data_d;
    logic        rb_open_q, rb_open_d, rb_commit_q, rb_commit_d;
    logic        rb_rollback_q, rb_rollback_d, pkt_ok_q, pkt_ok_d, pkt_drop_q, pkt_drop_d;

    logic           in_pkt, inflight, done_now, capture, overrun, oversize, abort_now;
    logic [CNT_W:0] words_acc;
    logic           gap_clr, gap_en, gap_expire;

    // The trailer handshake reuses WAIT; trailer_q keeps it out of packet accounting.
    assign inflight  = (state_q == ST_PUSH) || (state_q == ST_WAIT && !trailer_q);
    assign in_pkt    = inflight || (state_q == ST_GAP);
    assign done_now  = (state_q == ST_WAIT) && push_done;
    assign capture   = in_valid && (in_pkt || (state_q == ST_IDLE && !in_error));
    assign overrun   = full_q && !done_now;
    assign words_acc = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight};
    assign oversize  = words_acc >= (CNT_W + 1)'(MAX_WORDS);
    assign abort_now = in_pkt && in_valid && (in_error || overrun || oversize);

    assign gap_en  = (state_q == ST_GAP) || (state_q == ST_DISCARD);
    assign gap_clr = in_valid || !gap_en;

    gap_timer #(.CNT_W(CNT_W), .LIMIT(GAP_CYCLES)) u_gap_timer (
        .clk      (clk),
        .nRst     (nRst),
        .clr_i    (gap_clr),
        .en_i     (gap_en),
        .expire_o (gap_expire)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaulting every comb output first prevents latch inference.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (in_valid) state_d = in_error ? ST_DISCARD : ST_PUSH;
            ST_PUSH:     state_d = ST_WAIT;
            ST_WAIT: begin
                if (push_done) begin
                    if (trailer_q)                 state_d = ST_COMMIT;
                    else if (abort_q || abort_now) state_d = ST_ROLLBACK;
                    else if (in_valid)             state_d = ST_PUSH;
                    else                           state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (abort_now)     state_d = ST_ROLLBACK;
                else if (in_valid) state_d = ST_PUSH;
                else if (gap_expire) begin
`ifdef RING_PACKET_TRAILER_EN
                    state_d = ST_TRAILER;
`else
                    state_d = ST_COMMIT;
`endif
                end
            end
            ST_TRAILER:  state_d = ST_WAIT;
            ST_COMMIT:   state_d = ST_IDLE;
            ST_ROLLBACK: state_d = ST_DISCARD;
            ST_DISCARD:  if (gap_expire) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        push_request_d = 1'b0;
        push_data_d    = push_data_q;
        rb_open_d      = 1'b0;
        rb_commit_d    = 1'b0;
        rb_rollback_d  = 1'b0;
        pkt_ok_d       = 1'b0;
        pkt_drop_d     = 1'b0;
        unique case (state_q)
            ST_IDLE:     rb_open_d = in_valid && !in_error;
            ST_PUSH: begin
                push_request_d = 1'b1;
                push_data_d    = hold_q;
            end
            ST_WAIT:     push_request_d = !push_done;
            ST_TRAILER: begin
                push_request_d = 1'b1;
                push_data_d    = {TRAILER_TAG, 12'(count_q)};
            end
            ST_COMMIT: begin
                rb_commit_d = 1'b1;
                pkt_ok_d    = 1'b1;
            end
            ST_ROLLBACK: begin
                rb_rollback_d = 1'b1;
                pkt_drop_d    = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs are registered, which yields the one-cycle open-before-push spacing.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            push_request_q <= 1'b0;
            push_data_q    <= '0;
            rb_open_q      <= 1'b0;
            rb_commit_q    <= 1'b0;
            rb_rollback_q  <= 1'b0;
            pkt_ok_q       <= 1'b0;
            pkt_drop_q     <= 1'b0;
        end else begin
            push_request_q <= push_request_d;
            push_data_q    <= push_data_d;
            rb_open_q      <= rb_open_d;
            rb_commit_q    <= rb_commit_d;
            rb_rollback_q  <= rb_rollback_d;
            pkt_ok_q       <= pkt_ok_d;
            pkt_drop_q     <= pkt_drop_d;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hold_q    <= '0;
            full_q    <= 1'b0;
            count_q   <= '0;
            abort_q   <= 1'b0;
            trailer_q <= 1'b0;
        end else begin
            if (capture) hold_q <= in_data;

            if (state_q inside {ST_COMMIT, ST_ROLLBACK, ST_DISCARD}) full_q <= 1'b0;
            else if (capture)                                        full_q <= 1'b1;
            else if (done_now && !trailer_q)                         full_q <= 1'b0;

            if (state_q == ST_IDLE)          count_q <= '0;
            else if (done_now && !trailer_q) count_q <= count_q + CNT_W'(1);

            if (state_q inside {ST_IDLE, ST_ROLLBACK}) abort_q <= 1'b0;
            else if (abort_now && inflight)            abort_q <= 1'b1;

            if (state_q == ST_TRAILER)     trailer_q <= 1'b1;
            else if (state_q == ST_COMMIT) trailer_q <= 1'b0;
        end
    end

    assign push_request = push_request_q;
    assign push_data    = push_data_q;
    assign rb_open      = rb_open_q;
    assign rb_commit    = rb_commit_q;
    assign rb_rollback  = rb_rollback_q;
    assign pkt_ok       = pkt_ok_q;
    assign pkt_drop     = pkt_drop_q;

endmodule

// File: tb/tb_ring_packet_writer.sv
// Scoreboard bench for ring_packet_writer with a behavioural ring buffer
// that acknowledges pushes after a programmable latency.
module tb_ring_packet_writer;

    localparam int GAP  = 40;
    localparam int MAXW = 4;
    localparam int SP   = 8;
    localparam int SETTLE = GAP + 30;

    logic        clk = 1'b0;
    logic        nRst, in_valid, in_error, push_done;
    logic [15:0] in_data;
    logic        push_request, rb_open, rb_commit, rb_rollback, pkt_ok, pkt_drop;
    logic [15:0] push_data;

    always #5 clk = ~clk;

    ring_packet_writer #(.GAP_CYCLES(GAP), .MAX_WORDS(MAXW), .CNT_W(16)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_error     (in_error),
        .push_request (push_request),
        .push_data    (push_data),
        .push_done    (push_done),
        .rb_open      (rb_open),
        .rb_commit    (rb_commit),
        .rb_rollback  (rb_rollback),
        .pkt_ok       (pkt_ok),
        .pkt_drop     (pkt_drop)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] pend_q[$];
    int n_open = 0, n_commit = 0, n_rollback = 0, n_ok = 0, n_drop = 0, n_push = 0;
    int lat = 2;
    int lat_cnt = 0;
    logic prev_ctl = 1'b0;

    // Ring buffer model: acknowledges a held request after lat+1 cycles.
    always @(posedge clk) begin
        #1;
        if (!nRst) begin
            push_done = 1'b0;
            lat_cnt   = 0;
        end else if (push_done) begin
            push_done = 1'b0;
        end else if (push_request) begin
            if (lat_cnt >= lat) begin
                push_done = 1'b1;
                pend_q.push_back(push_data);
                n_push++;
                lat_cnt = 0;
            end else begin
                lat_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (rb_open)     n_open++;
        if (rb_commit)   n_commit++;
        if (rb_rollback) n_rollback++;
        if (pkt_ok)      n_ok++;
        if (pkt_drop)    n_drop++;
        if (rb_open || rb_commit || rb_rollback) begin
            vectors++;
            if ((int'(rb_open) + int'(rb_commit) + int'(rb_rollback)) != 1 || prev_ctl) begin
                miscompares++;
                $display("FAIL ctl_exclusive: open=%b commit=%b rollback=%b prev=%b, required single isolated pulse",
                         rb_open, rb_commit, rb_rollback, prev_ctl);
            end
        end
        prev_ctl = rb_open || rb_commit || rb_rollback;
        if (rb_commit) begin
            vectors++;
            if (pkt_ok !== 1'b1) begin
                miscompares++;
                $display("FAIL commit_pkt_ok: got %b required 1", pkt_ok);
            end
            while (pend_q.size() > 0) begin
                logic [15:0] w, e;
                w = pend_q.pop_front();
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL commit_word: got %h required nothing", w);
                end else begin
                    e = exp_q.pop_front();
                    if (w !== e) begin
                        miscompares++;
                        $display("FAIL commit_word: got %h required %h", w, e);
                    end
                end
            end
        end
        if (rb_rollback) begin
            pend_q.delete();
            vectors++;
            if (pkt_drop !== 1'b1) begin
                miscompares++;
                $display("FAIL rollback_pkt_drop: got %b required 1", pkt_drop);
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic e, input int space);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_error = e;
        @(posedge clk); #1;
        in_valid = 1'b0; in_error = 1'b0;
        repeat (space) @(posedge clk);
    endtask

    task automatic exp_trailer(input int n);
`ifdef RING_PACKET_TRAILER_EN
        exp_q.push_back({4'hA, 12'(n)});
`else
        if (n < 0) exp_q.push_back(16'h0);
`endif
    endtask

    task automatic expect_deltas(input string name, input int o0, input int c0, input int r0,
                                 input int d0, input int p0, input int eo, input int ec,
                                 input int er, input int ed, input int ep);
        vectors++;
        if (n_open - o0 != eo || n_commit - c0 != ec || n_rollback - r0 != er ||
            n_drop - d0 != ed || n_push - p0 != ep) begin
            miscompares++;
            $display("FAIL %s: open/commit/rollback/drop/push got %0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d",
                     name, n_open - o0, n_commit - c0, n_rollback - r0, n_drop - d0, n_push - p0,
                     eo, ec, er, ed, ep);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({push_request, push_data, rb_open, rb_commit, rb_rollback, pkt_ok, pkt_drop} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req=%b data=%h ctl=%b%b%b%b%b required all 0",
                     push_request, push_data, rb_open, rb_commit, rb_rollback, pkt_ok, pkt_drop);
        end
    endtask

    task automatic test_two_words();
        int o0 = n_open, c0 = n_commit, r0 = n_rollback, d0 = n_drop, p0 = n_push;
        exp_q.push_back(16'hABCD); exp_q.push_back(16'h1234); exp_trailer(2);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'hABCD; in_error = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (rb_open !== 1'b1 || push_request !== 1'b0) begin
            miscompares++;
            $display("FAIL open_timing: open=%b req=%b required 1/0", rb_open, push_request);
        end
        @(posedge clk); #1;
        vectors++;
        if (rb_open !== 1'b0 || push_request !== 1'b1 || push_data !== 16'hABCD) begin
            miscompares++;
            $display("FAIL push_timing: open=%b req=%b data=%h required 0/1/abcd", rb_open, push_request, push_data);
        end
        repeat (SP) @(posedge clk);
        send(16'h1234, 1'b0, SETTLE);
`ifdef RING_PACKET_TRAILER_EN
        expect_deltas("two_words", o0, c0, r0, d0, p0, 1, 1, 0, 0, 3);
`else
        expect_deltas("two_words", o0, c0, r0, d0, p0, 1, 1, 0, 0, 2);
`endif
    endtask

    task automatic test_error_word();
        int o0 = n_open, c0 = n_commit, r0 = n_rollback, d0 = n_drop, p0 = n_push;
        send(16'h1111, 1'b0, SP);
        send(16'h2222, 1'b1, SP);
        send(16'h3333, 1'b0, SETTLE);
        expect_deltas("error_word", o0, c0, r0, d0, p0, 1, 0, 1, 1, 1);
    endtask

    task automatic test_first_word_error();
        int o0 = n_open, c0 = n_commit, r0 = n_rollback, d0 = n_drop, p0 = n_push;
        send(16'hDEAD, 1'b1, SETTLE);
        expect_deltas("first_word_error", o0, c0, r0, d0, p0, 0, 0, 0, 0, 0);
        o0 = n_open; c0 = n_commit; r0 = n_rollback; d0 = n_drop; p0 = n_push;
        exp_q.push_back(16'h5A5A); exp_trailer(1);
        send(16'h5A5A, 1'b0, SETTLE);
`ifdef RING_PACKET_TRAILER_EN
        expect_deltas("after_first_error", o0, c0, r0, d0, p0, 1, 1, 0, 0, 2);
`else
        expect_deltas("after_first_error", o0, c0, r0, d0, p0, 1, 1, 0, 0, 1);
`endif
    endtask

    task automatic test_oversize();
        int o0 = n_open, c0 = n_commit, r0 = n_rollback, d0 = n_drop, p0 = n_push;
        for (int i = 0; i <= MAXW; i++) send(16'h0100 + 16'(i), 1'b0, (i == MAXW) ? SETTLE : SP);
        expect_deltas("oversize", o0, c0, r0, d0, p0, 1, 0, 1, 1, MAXW);
    endtask

    task automatic test_overrun();
        int o0 = n_open, c0 = n_commit, r0 = n_rollback, d0 = n_drop, p0 = n_push;
        lat = 10;
        send(16'h0A0A, 1'b0, 2);
        send(16'h0B0B, 1'b0, 2);
        send(16'h0C0C, 1'b0, SETTLE);
        lat = 2;
        expect_deltas("overrun", o0, c0, r0, d0, p0, 1, 0, 1, 1, 1);
    endtask

    task automatic test_back_to_back();
        int o0 = n_open, c0 = n_commit, r0 = n_rollback, d0 = n_drop, p0 = n_push;
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hC000 + 16'(i));
        exp_trailer(4);
        send(16'hC000, 1'b0, SP);
        send(16'hC001, 1'b0, GAP - 2);
        send(16'hC002, 1'b0, SP);
        send(16'hC003, 1'b0, SETTLE);
`ifdef RING_PACKET_TRAILER_EN
        expect_deltas("merged", o0, c0, r0, d0, p0, 1, 1, 0, 0, 5);
`else
        expect_deltas("merged", o0, c0, r0, d0, p0, 1, 1, 0, 0, 4);
`endif
    endtask

    task automatic test_split();
        int o0 = n_open, c0 = n_commit, r0 = n_rollback, d0 = n_drop, p0 = n_push;
        exp_q.push_back(16'hD000); exp_q.push_back(16'hD001); exp_trailer(2);
        exp_q.push_back(16'hD002); exp_q.push_back(16'hD003); exp_trailer(2);
        send(16'hD000, 1'b0, SP);
        send(16'hD001, 1'b0, GAP + 10);
        send(16'hD002, 1'b0, SP);
        send(16'hD003, 1'b0, SETTLE);
`ifdef RING_PACKET_TRAILER_EN
        expect_deltas("split", o0, c0, r0, d0, p0, 2, 2, 0, 0, 6);
`else
        expect_deltas("split", o0, c0, r0, d0, p0, 2, 2, 0, 0, 4);
`endif
    endtask

    task automatic test_reset_mid_packet();
        int o0 = n_open, c0 = n_commit, r0 = n_rollback, d0 = n_drop, p0;
        send(16'hE000, 1'b0, SP);
        send(16'hE001, 1'b0, 2);
        @(posedge clk); #3;
        nRst = 1'b0;
        #1;
        vectors++;
        if ({push_request, push_data, rb_open, rb_commit, rb_rollback, pkt_ok, pkt_drop} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got req=%b data=%h ctl=%b%b%b%b%b required all 0",
                     push_request, push_data, rb_open, rb_commit, rb_rollback, pkt_ok, pkt_drop);
        end
        pend_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) nRst = 1'b1;
        repeat (SETTLE) @(posedge clk);
        expect_deltas("mid_reset", o0, c0, r0, d0, n_push, 1, 0, 0, 0, 0);
        o0 = n_open; c0 = n_commit; r0 = n_rollback; d0 = n_drop; p0 = n_push;
        exp_q.push_back(16'hF00D); exp_trailer(1);
        send(16'hF00D, 1'b0, SETTLE);
`ifdef RING_PACKET_TRAILER_EN
        expect_deltas("after_reset", o0, c0, r0, d0, p0, 1, 1, 0, 0, 2);
`else
        expect_deltas("after_reset", o0, c0, r0, d0, p0, 1, 1, 0, 0, 1);
`endif
    endtask

    initial begin
        nRst = 1'b0; in_valid = 1'b0; in_error = 1'b0; in_data = '0; push_done = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        nRst = 1'b1;
        repeat (2) @(posedge clk);
        test_two_words();
        test_error_word();
        test_first_word_error();
        test_oversize();
        test_overrun();
        test_back_to_back();
        test_split();
        test_reset_mid_packet();
        vectors++;
        if (exp_q.size() != 0 || pend_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_words: expected=%0d pending=%0d required 0/0", exp_q.size(), pend_q.size());
        end
        vectors++;
        if (n_ok != n_commit || n_drop != n_rollback) begin
            miscompares++;
            $display("FAIL pulse_totals: ok=%0d commit=%0d drop=%0d rollback=%0d required ok==commit, drop==rollback",
                     n_ok, n_commit, n_drop, n_rollback);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
